// File: rtl/riscv_ctrl_pkg.sv
// ============================================================================
// Module   : riscv_ctrl_pkg
// Brief    : Shared types and encodings for the multi-cycle RISC-V controller.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10
  } statetype;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [1:0] ALU_AND = 2'b00;
  localparam logic [1:0] ALU_OR  = 2'b01;
  localparam logic [1:0] ALU_ADD = 2'b10;
  localparam logic [1:0] ALU_SUB = 2'b11;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  function automatic logic [1:0] imm_src(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_decoder.sv
// ============================================================================
// Module   : alu_decoder
// Brief    : Maps ALUOp plus instruction fields onto the 2-bit ALUControl.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       op5_i,
  input  logic       funct7b5_i,
  output logic [1:0] alu_control_o
);

  always_comb begin
    alu_control_o = ALU_ADD;
    case (alu_op_i)
      ALUOP_ADD: alu_control_o = ALU_ADD;
      ALUOP_SUB: alu_control_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          // Only R-type (op[5]=1) can encode sub; I-type bit 30 is immediate.
          3'b000:  alu_control_o = (op5_i & funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b110:  alu_control_o = ALU_OR;
          3'b111:  alu_control_o = ALU_AND;
          default: alu_control_o = ALU_ADD;
        endcase
      end
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_controller.sv
// ============================================================================
// Module   : multicycle_controller
// Brief    : Main control FSM of the multi-cycle RISC-V core.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module multicycle_controller
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic [1:0] ALUControl
);

  statetype   state_q, state_d;
  logic       w_pc_update;
  logic       w_branch;
  logic [1:0] w_alu_op;

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = FETCH;
    w_pc_update = 1'b0;
    w_branch    = 1'b0;
    w_alu_op    = ALUOP_ADD;
    AdrSrc      = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    ResultSrc   = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    RegWrite    = 1'b0;
    case (state_q)
      FETCH: begin
        IRWrite     = 1'b1;
        ALUSrcB     = 2'b10;
        ResultSrc   = 2'b10;
        w_pc_update = 1'b1;
        state_d     = DECODE;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        case (op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXECUTER;
          OP_IALU:      state_d = EXECUTEI;
          OP_BEQ:       state_d = BEQ;
          OP_JAL:       state_d = JAL;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = (op == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        AdrSrc  = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      EXECUTER: begin
        ALUSrcA  = 2'b10;
        w_alu_op = ALUOP_FUNCT;
        state_d  = ALUWB;
      end
      EXECUTEI: begin
        ALUSrcA  = 2'b10;
        ALUSrcB  = 2'b01;
        w_alu_op = ALUOP_FUNCT;
        state_d  = ALUWB;
      end
      ALUWB:    RegWrite = 1'b1;
      BEQ: begin
        ALUSrcA  = 2'b10;
        w_alu_op = ALUOP_SUB;
        w_branch = 1'b1;
      end
      JAL: begin
        ALUSrcA     = 2'b01;
        ALUSrcB     = 2'b10;
        w_pc_update = 1'b1;
        state_d     = ALUWB;
      end
      default: state_d = FETCH;
    endcase
  end

  // Branch outcome feeds PCWrite combinationally from the ALU in the same cycle.
  assign PCWrite = w_pc_update | (w_branch & Zero);
  assign ImmSrc  = imm_src(op);

  alu_decoder u_alu_decoder (
    .alu_op_i      (w_alu_op),
    .funct3_i      (funct3),
    .op5_i         (op[5]),
    .funct7b5_i    (funct7b5),
    .alu_control_o (ALUControl)
  );

endmodule

`default_nettype wire
